line_drawer_arbiter: RTL and testbench



---
 rtl/plotter_pkg.sv | 18 +
 rtl/line_drawer_arbiter_rr_picker.sv | 39 +++
 rtl/line_drawer_arbiter.sv | 162 ++++++++++++++++
 tb/tb_line_drawer_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plotter_pkg.sv
// Shared plotter definitions: screen defaults, coordinate width helper and
// the arbiter state encoding.
package plotter_pkg;

    localparam int HOR_ACTIVE_PIXELS_DEF = 640;
    localparam int VER_ACTIVE_PIXELS_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    function automatic int coord_width(input int pixels);
        return $clog2(pixels);
    endfunction

endpackage

// File: rtl/line_drawer_arbiter_rr_picker.sv
// Combinational round-robin selector: first pending requester found after
// last_grant, wrapping modulo REQUESTERS.
module rr_picker #(
    parameter int REQUESTERS = 2,
    localparam int ID_WIDTH = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] pending,
    input  logic [ID_WIDTH-1:0]   last_grant,
    output logic [ID_WIDTH-1:0]   winner,
    output logic                  any
);

    localparam logic [ID_WIDTH:0] REQ_W = (ID_WIDTH + 1)'(REQUESTERS);

    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] idx;
    logic                found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        // Offsets 1..REQUESTERS; the last one revisits last_grant itself.
        for (int i = 1; i <= REQUESTERS; i++) begin
            sum = {1'b0, last_grant} + (ID_WIDTH + 1)'(i);
            if (sum >= REQ_W) begin
                sum = sum - REQ_W;
            end
            idx = ID_WIDTH'(sum);
            if (!found && pending[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        any = |pending;
    end

endmodule

// File: rtl/line_drawer_arbiter.sv
// Shares one line_drawer between several masters: per-master request latch,
// round-robin grant, and a start/ready handshake toward the drawer.
module line_drawer_arbiter
    import plotter_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = HOR_ACTIVE_PIXELS_DEF,
    parameter int VER_ACTIVE_PIXELS = VER_ACTIVE_PIXELS_DEF,
    parameter int REQUESTERS        = 2,
    localparam int X_WIDTH  = coord_width(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH  = coord_width(VER_ACTIVE_PIXELS),
    localparam int ID_WIDTH = $clog2(REQUESTERS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [REQUESTERS-1:0]         req_start,
    output logic [REQUESTERS-1:0]         req_ready,
    input  logic [REQUESTERS*X_WIDTH-1:0] req_x1,
    input  logic [REQUESTERS*X_WIDTH-1:0] req_x2,
    input  logic [REQUESTERS*Y_WIDTH-1:0] req_y1,
    input  logic [REQUESTERS*Y_WIDTH-1:0] req_y2,
    output logic [X_WIDTH-1:0]            x1,
    output logic [X_WIDTH-1:0]            x2,
    output logic [Y_WIDTH-1:0]            y1,
    output logic [Y_WIDTH-1:0]            y2,
    output logic                          line_drawer_start,
    input  logic                          line_drawer_ready,
    output logic [ID_WIDTH-1:0]           grant,
    output logic                          busy
);

    arb_state_e state_q, state_d;

    logic [REQUESTERS-1:0] pending_q, pending_d;
    logic [X_WIDTH-1:0]    lat_x1_q [REQUESTERS];
    logic [X_WIDTH-1:0]    lat_x1_d [REQUESTERS];
    logic [X_WIDTH-1:0]    lat_x2_q [REQUESTERS];
    logic [X_WIDTH-1:0]    lat_x2_d [REQUESTERS];
    logic [Y_WIDTH-1:0]    lat_y1_q [REQUESTERS];
    logic [Y_WIDTH-1:0]    lat_y1_d [REQUESTERS];
    logic [Y_WIDTH-1:0]    lat_y2_q [REQUESTERS];
    logic [Y_WIDTH-1:0]    lat_y2_d [REQUESTERS];

    logic [X_WIDTH-1:0]  x1_q, x1_d, x2_q, x2_d;
    logic [Y_WIDTH-1:0]  y1_q, y1_d, y2_q, y2_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic                busy_q, busy_d;
    logic                start_q, start_d;

    logic [ID_WIDTH-1:0] winner;
    logic                any_pending;

    rr_picker #(
        .REQUESTERS (REQUESTERS)
    ) u_rr_picker (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any        (any_pending)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        lat_x1_d     = lat_x1_q;
        lat_x2_d     = lat_x2_q;
        lat_y1_d     = lat_y1_q;
        lat_y2_d     = lat_y2_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        y1_d         = y1_q;
        y2_d         = y2_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        start_d      = 1'b0;

        for (int i = 0; i < REQUESTERS; i++) begin
            if (req_start[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                lat_x1_d[i]  = req_x1[i*X_WIDTH +: X_WIDTH];
                lat_x2_d[i]  = req_x2[i*X_WIDTH +: X_WIDTH];
                lat_y1_d[i]  = req_y1[i*Y_WIDTH +: Y_WIDTH];
                lat_y2_d[i]  = req_y2[i*Y_WIDTH +: Y_WIDTH];
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Waiting on ready here lets a line that survived a reset finish.
                if (line_drawer_ready && any_pending) begin
                    x1_d    = lat_x1_q[winner];
                    x2_d    = lat_x2_q[winner];
                    y1_d    = lat_y1_q[winner];
                    y2_d    = lat_y2_q[winner];
                    grant_d = winner;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (line_drawer_ready) begin
                    pending_d[grant_q] = 1'b0;
                    last_grant_d       = grant_q;
                    busy_d             = 1'b0;
                    state_d            = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            lat_x1_q     <= '{default: '0};
            lat_x2_q     <= '{default: '0};
            lat_y1_q     <= '{default: '0};
            lat_y2_q     <= '{default: '0};
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(REQUESTERS - 1);
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            lat_x1_q     <= lat_x1_d;
            lat_x2_q     <= lat_x2_d;
            lat_y1_q     <= lat_y1_d;
            lat_y2_q     <= lat_y2_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            y1_q         <= y1_d;
            y2_q         <= y2_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
        end
    end

    assign req_ready         = ~pending_q;
    assign x1                = x1_q;
    assign x2                = x2_q;
    assign y1                = y1_q;
    assign y2                = y2_q;
    assign grant             = grant_q;
    assign busy              = busy_q;
    assign line_drawer_start = start_q;

endmodule

// File: tb/tb_line_drawer_arbiter.sv
// Bench for line_drawer_arbiter: drawer model, scoreboard of expected lines
// checked on every start pulse, and directed handshake scenarios.
module tb_line_drawer_arbiter;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int NR = 2;

    typedef struct packed {
        logic [0:0]    id;
        logic [XW-1:0] x1;
        logic [YW-1:0] y1;
        logic [XW-1:0] x2;
        logic [YW-1:0] y2;
    } line_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req_start = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*XW-1:0] req_x1 = '0, req_x2 = '0;
    logic [NR*YW-1:0] req_y1 = '0, req_y2 = '0;
    logic [XW-1:0]    x1, x2;
    logic [YW-1:0]    y1, y2;
    logic             line_drawer_start;
    logic             line_drawer_ready;
    logic [0:0]       grant;
    logic             busy;

    line_drawer_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .req_start         (req_start),
        .req_ready         (req_ready),
        .req_x1            (req_x1),
        .req_x2            (req_x2),
        .req_y1            (req_y1),
        .req_y2            (req_y2),
        .x1                (x1),
        .x2                (x2),
        .y1                (y1),
        .y2                (y2),
        .line_drawer_start (line_drawer_start),
        .line_drawer_ready (line_drawer_ready),
        .grant             (grant),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_miss = 0;
    int    cyc = 0;
    int    start_cnt = 0;
    int    last_start_cyc = 0;
    logic  prev_start = 1'b0;
    line_t sb[$];

    logic mdl_ready = 1'b1;
    logic hold = 1'b0;
    int   mdl_cnt = 0;
    assign line_drawer_ready = mdl_ready & ~hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Drawer model: drops ready after a start and stays busy for 8 cycles.
    always @(negedge clk) begin
        if (line_drawer_start) begin
            mdl_ready = 1'b0;
            mdl_cnt   = 8;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) mdl_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (line_drawer_start) begin
            line_t e;
            start_cnt++;
            last_start_cyc = cyc;
            chk("start_width", 32'(prev_start), 0);
            chk("busy_at_start", 32'(busy), 1);
            chk("sb_avail", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("grant", 32'(grant), 32'(e.id));
                chk("x1", 32'(x1), 32'(e.x1));
                chk("y1", 32'(y1), 32'(e.y1));
                chk("x2", 32'(x2), 32'(e.x2));
                chk("y2", 32'(y2), 32'(e.y2));
            end
        end
        prev_start = line_drawer_start;
    end

    task automatic load(input int r, input int ax1, input int ay1, input int ax2,
                        input int ay2, input bit expect_line);
        line_t e;
        req_x1[r*XW +: XW] = XW'(ax1);
        req_y1[r*YW +: YW] = YW'(ay1);
        req_x2[r*XW +: XW] = XW'(ax2);
        req_y2[r*YW +: YW] = YW'(ay2);
        req_start[r] = 1'b1;
        if (expect_line) begin
            e.id = 1'(r);
            e.x1 = XW'(ax1);
            e.y1 = YW'(ay1);
            e.x2 = XW'(ax2);
            e.y2 = YW'(ay2);
            sb.push_back(e);
        end
    endtask

    task automatic end_pulse();
        @(negedge clk);
        req_start = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        start_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400; k++) begin
            if (!busy && (&req_ready) && sb.size() == 0) break;
            @(negedge clk);
        end
        chk(tag, 32'(!busy && (&req_ready) && sb.size() == 0), 1);
    endtask

    task automatic wait_rdy(input int r, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 1);
    endtask

    int req_cyc, done_cyc, rel_cyc;

    initial begin
        // Single request, reset values and latency
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 3);
        chk("rst_start", 32'(line_drawer_start), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_x1", 32'(x1), 0);
        chk("rst_y2", 32'(y2), 0);
        req_cyc = cyc;
        load(0, 10, 20, 100, 200, 1'b1);
        end_pulse();
        chk("rdy0_low", 32'(req_ready[0]), 0);
        wait_rdy(0, "single_done");
        done_cyc = cyc;
        chk("start_latency", 32'(last_start_cyc - req_cyc), 2);
        chk("done_latency", 32'(done_cyc - req_cyc), 11);
        chk("single_starts", 32'(start_cnt), 1);
        wait_idle("single_idle");

        // Simultaneous requests
        do_reset();
        load(0, 1, 2, 3, 4, 1'b1);
        load(1, 600, 470, 5, 6, 1'b1);
        end_pulse();
        wait_idle("simul_idle");
        repeat (20) @(negedge clk);
        chk("simul_starts", 32'(start_cnt), 2);

        // Fairness: both keep re-requesting as soon as they are free
        do_reset();
        load(0, 11, 12, 13, 14, 1'b1);
        load(1, 21, 22, 23, 24, 1'b1);
        end_pulse();
        for (int k = 0; k < 4; k++) begin
            wait_rdy(k % 2, "fair_rdy");
            load(k % 2, 100 + k, 200 + k, 300 + k, 400 + k, 1'b1);
            end_pulse();
        end
        wait_idle("fair_idle");
        chk("fair_starts", 32'(start_cnt), 6);

        // Pulse while not ready is ignored
        do_reset();
        load(0, 5, 6, 7, 8, 1'b1);
        end_pulse();
        repeat (3) @(negedge clk);
        load(0, 300, 400, 500, 300, 1'b0);
        end_pulse();
        wait_idle("ign_idle");
        repeat (20) @(negedge clk);
        chk("ign_starts", 32'(start_cnt), 1);

        // Drawer busy at reset exit
        hold = 1'b1;
        do_reset();
        load(1, 40, 50, 60, 70, 1'b1);
        end_pulse();
        repeat (18) @(negedge clk);
        chk("hold_no_start", 32'(start_cnt), 0);
        chk("hold_busy", 32'(busy), 0);
        hold = 1'b0;
        rel_cyc = cyc;
        wait_idle("hold_idle");
        chk("hold_starts", 32'(start_cnt), 1);
        chk("hold_latency", 32'(last_start_cyc - rel_cyc), 1);

        // Reset during WAIT
        do_reset();
        load(0, 77, 88, 99, 111, 1'b1);
        end_pulse();
        repeat (4) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_req_ready", 32'(req_ready), 3);
        chk("mid_start", 32'(line_drawer_start), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load(1, 123, 234, 345, 456, 1'b1);
        end_pulse();
        wait_idle("mid_idle");
        chk("mid_starts", 32'(start_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
